// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Central pipeline sequencer for the 5-stage core. It produces the shared
// stall[5:0] hold bus, the ID/EX and EX/MEM bubble controls, the branch flush,
// and the EX-stage operand forwarding selects. It also sequences multi-cycle EX
// operations (MUL/DIV) with a timeout, and keeps a saturating count of stalled
// cycles for performance monitoring.
//
// Parameters
//   MC_TIMEOUT  cycles spent waiting for mc_done before giving up (sets mc_err)
//   CNT_W       width of the stall-cycle counter
//
// Ports
//   clk            core clock
//   rst            asynchronous reset, active low
//   id_rs1/id_rs2  source registers of the instruction in ID
//   id_use1/2      ID instruction really reads rs1 / rs2
//   ex_rs1/ex_rs2  source registers of the instruction in EX
//   ex_write_num   EX destination register
//   ex_write_reg   EX instruction writes a register
//   ex_is_load     EX instruction is a load
//   ex_mc_op       EX instruction is a multi-cycle op
//   mc_done        multi-cycle unit result valid (single-cycle pulse)
//   mem_write_num  EX/MEM destination register
//   mem_write_reg  EX/MEM writes a register
//   wb_write_num   MEM/WB destination register
//   wb_write_reg   MEM/WB writes a register
//   br_taken       branch/jump resolved taken in EX
//   mem_stall_req  data memory not ready
//   stall          bit i holds stage register i (0 PC .. 5 WB)
//   idex_bubble    load ID/EX with a NOP this edge
//   exmem_bubble   load EX/MEM with a NOP this edge
//   flush          clear IF/ID and ID/EX this edge
//   fwd_a/fwd_b    EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   mc_start       single-cycle pulse launching the multi-cycle unit
//   mc_err         sticky flag: a multi-cycle op timed out
//   stall_cnt      number of cycles with stall != 0, saturating
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_write_num,
    input  logic             ex_write_reg,
    input  logic             ex_is_load,
    input  logic             ex_mc_op,
    input  logic             mc_done,
    input  logic [4:0]       mem_write_num,
    input  logic             mem_write_reg,
    input  logic [4:0]       wb_write_num,
    input  logic             wb_write_reg,
    input  logic             br_taken,
    input  logic             mem_stall_req,
    output logic [5:0]       stall,
    output logic             idex_bubble,
    output logic             exmem_bubble,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mc_start,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cnt
);

    // Timeout counter only has to reach MC_TIMEOUT-1.
    localparam int            TW      = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(MC_TIMEOUT - 1);

    // Stall patterns on the hold bus.
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_MC   = 6'b000111;
    localparam logic [5:0] STALL_LOAD = 6'b000011;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t        state;
    logic [TW-1:0] to_ctr;

    logic          load_use;
    logic          mc_timeout;
    logic          mc_hold;

    logic [5:0]    stall_c;
    logic          idex_bubble_c;
    logic          exmem_bubble_c;
    logic          flush_c;
    logic          mc_start_c;
    logic [1:0]    fwd_a_c;
    logic [1:0]    fwd_b_c;

    // Forwarding source for one EX operand. The youngest producer (EX/MEM)
    // wins over MEM/WB, and x0 is never forwarded since it always reads zero.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic       m_we,
        input logic [4:0] m_num,
        input logic       w_we,
        input logic [4:0] w_num
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_we && (m_num != 5'd0) && (m_num == rs)) begin
            sel = 2'b01;
        end else if (w_we && (w_num != 5'd0) && (w_num == rs)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    // Hazard conditions. A load-use hazard needs a real destination (not x0)
    // that a source the ID instruction actually reads depends on. The timeout
    // fires on the last allowed waiting cycle; that cycle releases the pipeline
    // just like mc_done would, so the stuck op leaves EX instead of relaunching.
    always_comb begin
        load_use = ex_is_load && ex_write_reg && (ex_write_num != 5'd0) &&
                   ((id_use1 && (id_rs1 == ex_write_num)) ||
                    (id_use2 && (id_rs2 == ex_write_num)));
        mc_timeout = (state == MC_WAIT) && (to_ctr == TO_LAST);
        mc_hold    = ((state == RUN) && ex_mc_op) ||
                     ((state == MC_WAIT) && !mc_done && !mc_timeout);
    end

    // Per-cycle priority resolution. Memory stall freezes everything behind
    // WB and never bubbles or flushes, because the stage registers are not
    // allowed to move at all. A multi-cycle op holds PC..ID/EX and feeds
    // bubbles into EX/MEM. A taken branch squashes whatever sits in IF/ID and
    // ID/EX, so a load-use hazard in the same cycle is irrelevant.
    always_comb begin
        stall_c        = 6'b000000;
        idex_bubble_c  = 1'b0;
        exmem_bubble_c = 1'b0;
        flush_c        = 1'b0;
        mc_start_c     = 1'b0;
        if (mem_stall_req) begin
            stall_c = STALL_MEM;
        end else if (mc_hold) begin
            stall_c        = STALL_MC;
            exmem_bubble_c = 1'b1;
            mc_start_c     = (state == RUN);
        end else if (br_taken) begin
            flush_c = 1'b1;
        end else if (load_use) begin
            stall_c       = STALL_LOAD;
            idex_bubble_c = 1'b1;
        end
    end

    // Forwarding is independent of stalls so the EX operands stay correct
    // while the pipeline is held.
    always_comb begin
        fwd_a_c = fwd_select(ex_rs1, mem_write_reg, mem_write_num, wb_write_reg, wb_write_num);
        fwd_b_c = fwd_select(ex_rs2, mem_write_reg, mem_write_num, wb_write_reg, wb_write_num);
    end

    // While reset is asserted the combinational controls are forced quiet so
    // the pipeline registers see a clean, non-stalled state immediately.
    always_comb begin
        stall        = rst ? stall_c        : 6'b000000;
        idex_bubble  = rst ? idex_bubble_c  : 1'b0;
        exmem_bubble = rst ? exmem_bubble_c : 1'b0;
        flush        = rst ? flush_c        : 1'b0;
        mc_start     = rst ? mc_start_c     : 1'b0;
        fwd_a        = rst ? fwd_a_c        : 2'b00;
        fwd_b        = rst ? fwd_b_c        : 2'b00;
    end

    // Multi-cycle sequencer. A memory stall freezes the state and the timeout
    // counter; mc_done outside MC_WAIT has no meaning and is ignored. The
    // timeout error is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            to_ctr <= '0;
            mc_err <= 1'b0;
        end else if (!mem_stall_req) begin
            case (state)
                RUN: begin
                    if (ex_mc_op) begin
                        state  <= MC_WAIT;
                        to_ctr <= '0;
                    end
                end
                MC_WAIT: begin
                    if (mc_done) begin
                        state <= RUN;
                    end else if (mc_timeout) begin
                        state  <= RUN;
                        mc_err <= 1'b1;
                    end else begin
                        to_ctr <= to_ctr + 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Stall-cycle performance counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((stall_c != 6'b000000) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Self-checking bench for hazard_stall_ctrl. Directed scenarios cover reset,
// load-use, forwarding priority, multi-cycle sequencing, timeout, priority
// between memory stall / branch / load-use, counter saturation and an async
// reset during a multi-cycle wait; a randomized phase follows. Every cycle is
// compared against a behavioural model that tracks the multi-cycle wait as an
// elapsed-cycle count.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 6;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0] idRs1;
        logic [4:0] idRs2;
        logic       idUse1;
        logic       idUse2;
        logic [4:0] exRs1;
        logic [4:0] exRs2;
        logic [4:0] exWriteNum;
        logic       exWriteReg;
        logic       exIsLoad;
        logic       exMcOp;
        logic       mcDone;
        logic [4:0] memWriteNum;
        logic       memWriteReg;
        logic [4:0] wbWriteNum;
        logic       wbWriteReg;
        logic       brTaken;
        logic       memStallReq;
    } stim_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_write_num, mem_write_num, wb_write_num;
    logic             id_use1, id_use2, ex_write_reg, ex_is_load, ex_mc_op, mc_done;
    logic             mem_write_reg, wb_write_reg, br_taken, mem_stall_req;
    logic [5:0]       stall;
    logic             idex_bubble, exmem_bubble, flush, mc_start, mc_err;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    int checkCount = 0;
    int errCount   = 0;

    // Reference model state
    bit modelBusy;
    int modelWaited;
    bit modelErr;
    int modelCount;

    logic [5:0] expStall;
    logic       expIdex, expExmem, expFlush, expStart;
    logic [1:0] expFwdA, expFwdB;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .MC_TIMEOUT(MC_TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_write_num (ex_write_num),
        .ex_write_reg (ex_write_reg),
        .ex_is_load   (ex_is_load),
        .ex_mc_op     (ex_mc_op),
        .mc_done      (mc_done),
        .mem_write_num(mem_write_num),
        .mem_write_reg(mem_write_reg),
        .wb_write_num (wb_write_num),
        .wb_write_reg (wb_write_reg),
        .br_taken     (br_taken),
        .mem_stall_req(mem_stall_req),
        .stall        (stall),
        .idex_bubble  (idex_bubble),
        .exmem_bubble (exmem_bubble),
        .flush        (flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .mc_start     (mc_start),
        .mc_err       (mc_err),
        .stall_cnt    (stall_cnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [1:0] expectFwd(input stim_t s, input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (s.memWriteReg && s.memWriteNum == rs) return 2'b01;
        if (s.wbWriteReg && s.wbWriteNum == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic resetModel();
        modelBusy   = 1'b0;
        modelWaited = 0;
        modelErr    = 1'b0;
        modelCount  = 0;
    endtask

    // Expected combinational outputs for this cycle from the priority rules.
    task automatic predict(input stim_t s);
        bit loadUse;
        bit timedOut;
        expStall = 6'd0;
        expIdex  = 1'b0;
        expExmem = 1'b0;
        expFlush = 1'b0;
        expStart = 1'b0;
        expFwdA  = 2'b00;
        expFwdB  = 2'b00;
        if (rst) begin
            loadUse  = s.exIsLoad && s.exWriteReg && s.exWriteNum != 0 &&
                       ((s.idUse1 && s.idRs1 == s.exWriteNum) || (s.idUse2 && s.idRs2 == s.exWriteNum));
            timedOut = modelBusy && (modelWaited == MC_TIMEOUT - 1);
            if (s.memStallReq) begin
                expStall = 6'b011111;
            end else if ((!modelBusy && s.exMcOp) || (modelBusy && !s.mcDone && !timedOut)) begin
                expStall = 6'b000111;
                expExmem = 1'b1;
                expStart = !modelBusy;
            end else if (s.brTaken) begin
                expFlush = 1'b1;
            end else if (loadUse) begin
                expStall = 6'b000011;
                expIdex  = 1'b1;
            end
            expFwdA = expectFwd(s, s.exRs1);
            expFwdB = expectFwd(s, s.exRs2);
        end
    endtask

    // Advance the model by one clock edge.
    task automatic updateModel(input stim_t s);
        if (expStall != 0 && modelCount < CNT_MAX) modelCount++;
        if (!s.memStallReq) begin
            if (!modelBusy) begin
                if (s.exMcOp) begin
                    modelBusy   = 1'b1;
                    modelWaited = 0;
                end
            end else if (s.mcDone) begin
                modelBusy = 1'b0;
            end else if (modelWaited == MC_TIMEOUT - 1) begin
                modelBusy = 1'b0;
                modelErr  = 1'b1;
            end else begin
                modelWaited++;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("stall",        32'(stall),        32'(expStall));
        checkOutput("idex_bubble",  32'(idex_bubble),  32'(expIdex));
        checkOutput("exmem_bubble", 32'(exmem_bubble), 32'(expExmem));
        checkOutput("flush",        32'(flush),        32'(expFlush));
        checkOutput("fwd_a",        32'(fwd_a),        32'(expFwdA));
        checkOutput("fwd_b",        32'(fwd_b),        32'(expFwdB));
        checkOutput("mc_start",     32'(mc_start),     32'(expStart));
        checkOutput("mc_err",       32'(mc_err),       32'(modelErr));
        checkOutput("stall_cnt",    32'(stall_cnt),    32'(modelCount));
    endtask

    task automatic driveInputs(input stim_t s);
        id_rs1        = s.idRs1;
        id_rs2        = s.idRs2;
        id_use1       = s.idUse1;
        id_use2       = s.idUse2;
        ex_rs1        = s.exRs1;
        ex_rs2        = s.exRs2;
        ex_write_num  = s.exWriteNum;
        ex_write_reg  = s.exWriteReg;
        ex_is_load    = s.exIsLoad;
        ex_mc_op      = s.exMcOp;
        mc_done       = s.mcDone;
        mem_write_num = s.memWriteNum;
        mem_write_reg = s.memWriteReg;
        wb_write_num  = s.wbWriteNum;
        wb_write_reg  = s.wbWriteReg;
        br_taken      = s.brTaken;
        mem_stall_req = s.memStallReq;
    endtask

    // Drive a cycle's inputs away from the active edge and check all outputs.
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        driveInputs(s);
        #1;
        predict(s);
        checkAll();
    endtask

    task automatic finishCycle(input stim_t s);
        @(posedge clk);
        if (!rst) resetModel();
        else updateModel(s);
    endtask

    // Assert reset between clock edges and verify it acts immediately.
    task automatic doAsyncReset(input stim_t s);
        applyStimulus(s);
        #2 rst = 1'b0;
        resetModel();
        #1;
        predict(s);
        checkAll();
        checkOutput("arst_stall", 32'(stall), 32'h0);
        checkOutput("arst_err",   32'(mc_err), 32'h0);
        checkOutput("arst_cnt",   32'(stall_cnt), 32'h0);
        @(posedge clk);
        #3 rst = 1'b1;
    endtask

    function automatic stim_t randomStim();
        stim_t s;
        s.idRs1       = 5'($urandom_range(0, 3));
        s.idRs2       = 5'($urandom_range(0, 3));
        s.idUse1      = 1'($urandom_range(0, 1));
        s.idUse2      = 1'($urandom_range(0, 1));
        s.exRs1       = 5'($urandom_range(0, 3));
        s.exRs2       = 5'($urandom_range(0, 3));
        s.exWriteNum  = 5'($urandom_range(0, 3));
        s.exWriteReg  = 1'($urandom_range(0, 1));
        s.exIsLoad    = 1'($urandom_range(0, 1));
        s.exMcOp      = ($urandom_range(0, 5) == 0);
        s.mcDone      = ($urandom_range(0, 4) == 0);
        s.memWriteNum = 5'($urandom_range(0, 3));
        s.memWriteReg = 1'($urandom_range(0, 1));
        s.wbWriteNum  = 5'($urandom_range(0, 3));
        s.wbWriteReg  = 1'($urandom_range(0, 1));
        s.brTaken     = ($urandom_range(0, 7) == 0);
        s.memStallReq = ($urandom_range(0, 5) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        rst = 1'b0;
        resetModel();

        // Reset: busy inputs must not leak through to the outputs.
        s = '0;
        s.memStallReq = 1'b1;
        s.brTaken     = 1'b1;
        s.memWriteReg = 1'b1;
        s.memWriteNum = 5'd3;
        s.exRs1       = 5'd3;
        applyStimulus(s);
        checkOutput("rst_stall", 32'(stall), 32'h0);
        checkOutput("rst_fwd_a", 32'(fwd_a), 32'h0);
        finishCycle(s);
        #2 rst = 1'b1;

        // Load-use: LW x5 in EX, ADD reading x5 in ID.
        s = '0;
        s.exIsLoad = 1'b1; s.exWriteReg = 1'b1; s.exWriteNum = 5'd5;
        s.idUse1 = 1'b1; s.idRs1 = 5'd5; s.idRs2 = 5'd7;
        applyStimulus(s);
        checkOutput("lu_stall",  32'(stall), 32'h03);
        checkOutput("lu_bubble", 32'(idex_bubble), 32'h1);
        finishCycle(s);
        s = '0;
        s.memWriteReg = 1'b1; s.memWriteNum = 5'd5; s.idUse1 = 1'b1; s.idRs1 = 5'd5;
        applyStimulus(s);
        checkOutput("lu_release", 32'(stall), 32'h0);
        finishCycle(s);
        s = '0;
        s.exRs1 = 5'd5; s.wbWriteReg = 1'b1; s.wbWriteNum = 5'd5;
        applyStimulus(s);
        checkOutput("lu_fwd_a", 32'(fwd_a), 32'h2);
        finishCycle(s);
        // A load to x0 is never a hazard.
        s = '0;
        s.exIsLoad = 1'b1; s.exWriteReg = 1'b1; s.idUse2 = 1'b1;
        applyStimulus(s);
        checkOutput("lu_x0", 32'(stall), 32'h0);
        finishCycle(s);

        // Forwarding priority and x0.
        s = '0;
        s.memWriteReg = 1'b1; s.memWriteNum = 5'd3;
        s.wbWriteReg = 1'b1; s.wbWriteNum = 5'd3; s.exRs1 = 5'd3;
        applyStimulus(s);
        checkOutput("fwd_prio", 32'(fwd_a), 32'h1);
        finishCycle(s);
        s.memWriteNum = 5'd0; s.wbWriteNum = 5'd0; s.exRs1 = 5'd0; s.exRs2 = 5'd0;
        applyStimulus(s);
        checkOutput("fwd_x0", 32'(fwd_a), 32'h0);
        finishCycle(s);

        // Memory stall dominates branch and load-use; branch follows after.
        s = '0;
        s.memStallReq = 1'b1; s.brTaken = 1'b1;
        s.exIsLoad = 1'b1; s.exWriteReg = 1'b1; s.exWriteNum = 5'd2;
        s.idUse1 = 1'b1; s.idRs1 = 5'd2;
        applyStimulus(s);
        checkOutput("prio_stall", 32'(stall), 32'h1F);
        checkOutput("prio_flush", 32'(flush), 32'h0);
        finishCycle(s);
        s.memStallReq = 1'b0;
        applyStimulus(s);
        checkOutput("prio_flush_next", 32'(flush), 32'h1);
        checkOutput("prio_stall_next", 32'(stall), 32'h0);
        finishCycle(s);

        // Multi-cycle op finishing on the sixth cycle.
        s = '0;
        s.exMcOp = 1'b1;
        for (int c = 0; c < 6; c++) begin
            s.mcDone = (c == 5);
            applyStimulus(s);
            checkOutput("mc_start", 32'(mc_start), 32'(c == 0));
            checkOutput("mc_stall", 32'(stall), (c < 5) ? 32'h07 : 32'h0);
            finishCycle(s);
        end
        s = '0;
        applyStimulus(s);
        checkOutput("mc_idle", 32'(stall), 32'h0);
        finishCycle(s);

        // Timeout: mc_done never arrives.
        s = '0;
        s.exMcOp = 1'b1;
        for (int c = 0; c < 9; c++) begin
            applyStimulus(s);
            checkOutput("to_stall", 32'(stall), (c < 8) ? 32'h07 : 32'h0);
            checkOutput("to_err_pre", 32'(mc_err), 32'h0);
            finishCycle(s);
        end
        s = '0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(s);
            checkOutput("to_err_sticky", 32'(mc_err), 32'h1);
            finishCycle(s);
        end

        // Counter saturation under a long memory stall.
        s = '0;
        s.memStallReq = 1'b1;
        for (int c = 0; c < CNT_MAX + 8; c++) begin
            applyStimulus(s);
            finishCycle(s);
        end
        s = '0;
        applyStimulus(s);
        checkOutput("cnt_sat", 32'(stall_cnt), 32'(CNT_MAX));
        finishCycle(s);

        // Async reset while waiting on a multi-cycle op.
        s = '0;
        s.exMcOp = 1'b1;
        applyStimulus(s);
        finishCycle(s);
        applyStimulus(s);
        finishCycle(s);
        doAsyncReset(s);
        applyStimulus(s);
        checkOutput("arst_state_run", 32'(mc_start), 32'h1);
        finishCycle(s);

        // Randomized phase with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            s = randomStim();
            if ($urandom_range(0, 199) == 0) begin
                doAsyncReset(s);
            end else begin
                applyStimulus(s);
                finishCycle(s);
            end
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
